// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks the PC through instruction memory and
// queues {pc, instr} pairs in a 2-entry buffer toward decode.
module instr_fetch_ctrl #(
  parameter int unsigned         N          = 32,
  parameter int unsigned         AW         = 14,
  parameter logic [AW-1:0]       RESET_PC   = {AW{1'b0}},
  parameter logic [N-1:0]        HALT_INSTR = {N{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic [AW-1:0] imem_addr,
  input  logic [N-1:0]  imem_instr,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_instr,
  output logic [AW-1:0] out_pc,
  output logic          halted,
  output logic          align_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT, ERROR} state_t;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [N-1:0]  instr;
  } entry_t;

  state_t          state, state_nx;
  logic [AW-1:0]   pc, pc_nx;
  entry_t [1:0]    fifo, fifo_nx;   // [0] is the head
  logic [1:0]      cnt, cnt_nx;
  logic            err, err_nx;
  logic            redir_ok, redir_bad, pop, fetch;
  entry_t          fetched;

  assign redir_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
  // ERROR always has an empty buffer, so pop needs no state qualifier
  assign pop       = out_valid & out_ready & ~redirect_valid;
  assign fetch     = (state == FETCH) & enable & ~redirect_valid &
                     ((cnt != 2'd2) | pop);
  assign fetched   = '{pc: pc, instr: imem_instr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      fifo  <= '0;
      cnt   <= 2'd0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      fifo  <= fifo_nx;
      cnt   <= cnt_nx;
      err   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    fifo_nx  = fifo;
    cnt_nx   = cnt;
    err_nx   = err;
    if (state != ERROR) begin
      if (redir_bad) begin
        cnt_nx   = 2'd0;
        state_nx = ERROR;
        err_nx   = 1'b1;
      end else if (redir_ok) begin
        cnt_nx = 2'd0;
        pc_nx  = redirect_pc;
        if (state != IDLE) state_nx = FETCH;
      end else begin
        case (state)
          IDLE:    if (enable)  state_nx = FETCH;
          FETCH:   if (!enable) state_nx = IDLE;
          default: ;
        endcase
        // a fetched halt word is still delivered; PC parks on it
        if (fetch) begin
          if (imem_instr == HALT_INSTR) state_nx = HALT;
          else                          pc_nx    = pc + AW'(4);
        end
        case ({fetch, pop})
          2'b11: begin
            if (cnt == 2'd2) begin
              fifo_nx[0] = fifo[1];
              fifo_nx[1] = fetched;
            end else begin
              fifo_nx[0] = fetched;
            end
          end
          2'b10: begin
            fifo_nx[cnt[0]] = fetched;
            cnt_nx          = cnt + 2'd1;
          end
          2'b01: begin
            fifo_nx[0] = fifo[1];
            cnt_nx     = cnt - 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_addr = pc;
  assign out_valid = (cnt != 2'd0);
  assign out_instr = out_valid ? fifo[0].instr : '0;
  assign out_pc    = out_valid ? fifo[0].pc    : '0;
  assign halted    = (state == HALT) & (cnt == 2'd0);
  assign align_err = err;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed table, corner sequences, and random
// traffic checked against a queue-based reference model.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
  localparam logic [31:0] WA = 32'hC0DE_0000, WB = 32'hC0DE_0001, WC = 32'hC0DE_0002;
  localparam int MI = 0, MF = 1, MH = 2, ME = 3;

  logic        clk, rst, enable, redirect_valid, out_ready;
  logic [13:0] imem_addr, redirect_pc, out_pc;
  logic [31:0] imem_instr, out_instr;
  logic        out_valid, halted, align_err;

  logic [31:0] mem [4096];
  assign imem_instr = mem[imem_addr[13:2]];

  instr_fetch_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .halted(halted),
    .align_err(align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // reference model: FIFO as a queue, pc, mode and sticky error
  typedef struct { logic [13:0] pc; logic [31:0] instr; } ment_t;
  ment_t       mq[$];
  logic [13:0] mpc;
  int          mst;
  bit          merr;

  typedef struct {
    bit rst, en, rdy, v;
    logic [13:0] pc, addr;
    logic [31:0] ins;
  } vec_t;
  vec_t tbl[15];

  function automatic vec_t mk(bit r, bit e, bit y, bit v, logic [13:0] p,
                              logic [31:0] i, logic [13:0] a);
    vec_t t;
    t.rst = r; t.en = e; t.rdy = y; t.v = v; t.pc = p; t.ins = i; t.addr = a;
    return t;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete(); mpc = 14'h0000; mst = MI; merr = 1'b0;
  endtask

  task automatic model_step();
    ment_t e;
    bit popped, fet;
    int st0;
    if (mst == ME) return;
    if (redirect_valid) begin
      mq.delete();
      if (redirect_pc[1:0] != 2'b00) begin mst = ME; merr = 1'b1; end
      else begin mpc = redirect_pc; if (mst != MI) mst = MF; end
      return;
    end
    st0    = mst;
    popped = (mq.size() > 0) && out_ready;
    fet    = (st0 == MF) && enable && ((mq.size() < 2) || popped);
    e.pc = mpc; e.instr = mem[mpc >> 2];
    if (popped) void'(mq.pop_front());
    if (st0 == MI && enable) mst = MF;
    else if (st0 == MF && !enable) mst = MI;
    if (fet) begin
      mq.push_back(e);
      if (e.instr == HALTW) mst = MH;
      else mpc = 14'((int'(mpc) + 4) % 16384);
    end
  endtask

  // compare whole output set against the model, then advance one cycle
  task automatic tick();
    logic [63:0] exp;
    bit v;
    v   = mq.size() > 0;
    exp = {v, v ? mq[0].pc : 14'h0, v ? mq[0].instr : 32'h0, mpc,
           (mst == MH) && !v, merr};
    chk("model", {out_valid, out_pc, out_instr, imem_addr, halted, align_err}, exp);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0;
    #1;
    chk("reset", {out_valid, out_pc, out_instr, imem_addr, halted, align_err}, 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic mem_init();
    for (int w = 0; w < 4096; w++) mem[w] = WA | 32'(w);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    mem_init();
    model_reset();

    // streaming start, then back-pressure saturation and release
    tbl[0]  = mk(1, 1, 1, 0, 14'h0, 32'h0, 14'h0);
    tbl[1]  = mk(0, 1, 1, 0, 14'h0, 32'h0, 14'h0);
    tbl[2]  = mk(0, 1, 1, 1, 14'h0, WA,    14'h4);
    tbl[3]  = mk(0, 1, 1, 1, 14'h4, WB,    14'h8);
    tbl[4]  = mk(0, 1, 1, 1, 14'h8, WC,    14'hC);
    tbl[5]  = mk(1, 1, 0, 0, 14'h0, 32'h0, 14'h0);
    tbl[6]  = mk(0, 1, 0, 0, 14'h0, 32'h0, 14'h0);
    tbl[7]  = mk(0, 1, 0, 1, 14'h0, WA,    14'h4);
    tbl[8]  = mk(0, 1, 0, 1, 14'h0, WA,    14'h8);
    tbl[9]  = mk(0, 1, 0, 1, 14'h0, WA,    14'h8);
    tbl[10] = mk(0, 1, 0, 1, 14'h0, WA,    14'h8);
    tbl[11] = mk(0, 1, 0, 1, 14'h0, WA,    14'h8);
    tbl[12] = mk(0, 1, 1, 1, 14'h0, WA,    14'h8);
    tbl[13] = mk(0, 1, 1, 1, 14'h4, WB,    14'hC);
    tbl[14] = mk(0, 1, 1, 1, 14'h8, WC,    14'h10);

    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) do_reset();
      enable = tbl[i].en; out_ready = tbl[i].rdy;
      chk($sformatf("tbl%0d", i), {out_valid, out_pc, out_instr, imem_addr},
          {tbl[i].v, tbl[i].pc, tbl[i].ins, tbl[i].addr});
      tick();
    end

    // redirect while full: flushed, first new entry two cycles later
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    repeat (4) tick();
    chk("full_before_redir", {out_valid, out_pc, imem_addr}, {1'b1, 14'h0, 14'h8});
    redirect_valid = 1'b1; redirect_pc = 14'h0100;
    tick();
    redirect_valid = 1'b0; out_ready = 1'b1;
    chk("redir_t1", {out_valid, imem_addr}, {1'b0, 14'h0100});
    tick();
    chk("redir_t2", {out_valid, out_pc, out_instr}, {1'b1, 14'h0100, WA | 32'h40});
    tick();
    chk("redir_t3", {out_valid, out_pc, out_instr}, {1'b1, 14'h0104, WA | 32'h41});

    // halt word at 0x0C, then resume with a redirect to 0
    mem[3] = HALTW;
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    repeat (5) tick();
    chk("halt_entry", {out_valid, out_pc, out_instr, halted},
        {1'b1, 14'h000C, HALTW, 1'b0});
    tick();
    chk("halted", {out_valid, halted, imem_addr}, {1'b0, 1'b1, 14'h000C});
    tick();
    chk("halt_hold", {out_valid, halted, imem_addr}, {1'b0, 1'b1, 14'h000C});
    redirect_valid = 1'b1; redirect_pc = 14'h0000;
    tick();
    redirect_valid = 1'b0;
    chk("resume_t1", {out_valid, halted}, {1'b0, 1'b0});
    tick();
    chk("resume_t2", {out_valid, out_pc, out_instr}, {1'b1, 14'h0, WA});
    mem[3] = WA | 32'h3;

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 14'h3FFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("wrap_last", {out_valid, out_pc, out_instr}, {1'b1, 14'h3FFC, WA | 32'hFFF});
    tick();
    chk("wrap_first", {out_valid, out_pc, out_instr}, {1'b1, 14'h0000, WA});

    // misaligned redirect: sticky error, redirects ignored, reset clears
    redirect_valid = 1'b1; redirect_pc = 14'h0102;
    tick();
    redirect_valid = 1'b0;
    chk("err_set", {out_valid, align_err, halted}, {1'b0, 1'b1, 1'b0});
    redirect_valid = 1'b1; redirect_pc = 14'h0000;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    chk("err_sticky", {out_valid, align_err}, {1'b0, 1'b1});
    #2 rst = 1'b1;
    #1;
    chk("midcyc_rst", {out_valid, out_pc, out_instr, imem_addr, halted, align_err}, 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic with sparse halt words
    for (int w = 0; w < 4096; w++)
      mem[w] = ($urandom_range(0, 39) == 0) ? HALTW : $urandom;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) do_reset();
      enable    = $urandom_range(0, 9) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      redirect_valid = $urandom_range(0, 24) == 0;
      redirect_pc = 14'($urandom_range(0, 4095) << 2);
      if ($urandom_range(0, 15) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
